dm_resp_mem: RTL and testbench

Handshaked data-memory responder that serves load/store requests from the CPU's data port. Each accepted request is held for a programmable number of wait states, then committed to or read from a word-addressed array. The response is presented with valid/ready backpressure. It sits between the CPU memory stage and the physical data store and replaces the zero-latency combinational data memory for multi-cycle and pipelined cores.

---
 rtl/dm_resp_pkg.sv | 34 +++
 rtl/dm_store.sv | 51 +++++
 rtl/dm_resp_mem.sv | 194 +++++++++++++++++++
 tb/tb_dm_resp_mem.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_resp_pkg.sv
// dm_resp_pkg
//   Shared definitions for the handshaked data-memory responder:
//   - responder state encoding
//   - word geometry and the byte-alignment mask
//   - dm_addr_err(): classifies a byte address as misaligned or out of range
//
// Optional feature macro used by the responder: DM_RESP_BYTE_EN (byte-enable
// masking of stores). This package does not depend on it.

package dm_resp_pkg;

    localparam int DM_WORD_WIDTH = 32;
    localparam int DM_BYTES      = DM_WORD_WIDTH / 8;

    // Low address bits that must be zero for a word access.
    localparam logic [DM_WORD_WIDTH-1:0] DM_ALIGN_MASK = DM_WORD_WIDTH'(DM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dm_state_e;

    // True when the byte address is not word aligned or its word index falls
    // outside an array of 'depth' words.
    function automatic logic dm_addr_err(input logic [DM_WORD_WIDTH-1:0] addr,
                                         input int unsigned              depth);
        logic [DM_WORD_WIDTH-1:0] w_word_idx;
        w_word_idx = {2'b00, addr[DM_WORD_WIDTH-1:2]};
        return ((addr & DM_ALIGN_MASK) != '0) ||
               (w_word_idx >= DM_WORD_WIDTH'(depth));
    endfunction

endpackage

// File: rtl/dm_store.sv
// dm_store
//   Single-port word array behind the responder. Writes are synchronous with a
//   per-byte mask; reads are registered and only update when i_re is high, so
//   o_rdata holds the last read word until the next read.
//   The array has no reset: contents are undefined until written.
//
// Ports:
//   clk      in   clock, rising edge
//   i_we     in   write strobe (one cycle)
//   i_re     in   read strobe (one cycle)
//   i_addr   in   word index
//   i_wdata  in   write data
//   i_wmask  in   byte write mask, bit i covers bits 8i+7..8i
//   o_rdata  out  registered read data

module dm_store
    import dm_resp_pkg::*;
#(
    parameter int WORD_WIDTH  = DM_WORD_WIDTH,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                          clk,
    input  logic                          i_we,
    input  logic                          i_re,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
    input  logic [WORD_WIDTH-1:0]         i_wdata,
    input  logic [WORD_WIDTH/8-1:0]       i_wmask,
    output logic [WORD_WIDTH-1:0]         o_rdata
);

    localparam int NB = WORD_WIDTH / 8;

    logic [WORD_WIDTH-1:0] r_mem [DEPTH_WORDS];
    logic [WORD_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < NB; b++) begin
                if (i_wmask[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dm_resp_mem.sv
// dm_resp_mem
//   Handshaked data-memory responder. Accepts one load/store at a time, holds
//   it for WAIT_CYCLES wait states, commits it to the word array on a single
//   edge and presents the response with valid/ready backpressure.
//
//   Timing (acceptance on edge N):
//     edges N+1 .. N+WAIT_CYCLES : wait states (counter runs WAIT_CYCLES..1)
//     edge  N+WAIT_CYCLES+1      : commit, rsp_valid rises
//   req_ready is registered and rises on the edge that retires the response.
//
//   Configuration macro: DM_RESP_BYTE_EN
//     defined   - req_be masks the bytes a store writes (be = 0 writes nothing)
//     undefined - req_be is ignored and every store writes the full word
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  responder can accept a request (registered)
//   req_write  in   1 = store, 0 = load
//   req_addr   in   byte address
//   req_wdata  in   store data
//   req_be     in   byte enables
//   rsp_valid  out  response present
//   rsp_ready  in   requester takes the response
//   rsp_rdata  out  load data, 0 for stores and errors
//   rsp_err    out  misaligned or out-of-range request

module dm_resp_mem
    import dm_resp_pkg::*;
#(
    parameter int WORD_WIDTH  = DM_WORD_WIDTH,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [WORD_WIDTH-1:0]   req_addr,
    input  logic [WORD_WIDTH-1:0]   req_wdata,
    input  logic [WORD_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WORD_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int NB = WORD_WIDTH / 8;
    localparam int CW = 4;

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    dm_state_e             r_state;
    dm_state_e             w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic                  r_req_ready;
    logic                  r_write;
    logic [WORD_WIDTH-1:0] r_addr;
    logic [WORD_WIDTH-1:0] r_wdata;
    logic                  r_rsp_err;
    logic                  r_rsp_load;

    logic                  w_accept;
    logic                  w_commit;
    logic                  w_retire;
    logic                  w_addr_err;
    logic                  w_req_ready_nxt;
    logic                  w_mem_we;
    logic                  w_mem_re;
    logic [NB-1:0]         w_wmask;
    logic [WORD_WIDTH-1:0] w_mem_rdata;

`ifdef DM_RESP_BYTE_EN
    logic [NB-1:0]         r_be;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_be <= '0;
        end else if (w_accept) begin
            r_be <= req_be;
        end
    end

    assign w_wmask = r_be;
`else
    // Byte enables are not honoured in this build; the full word is written.
    logic w_unused_be;
    assign w_unused_be = ^req_be;
    assign w_wmask     = '1;
`endif

    // req_ready is only ever high in IDLE, so it alone qualifies acceptance.
    assign w_accept   = req_valid & r_req_ready;
    assign w_commit   = (r_state == WAIT) && (r_cnt == '0);
    assign w_retire   = (r_state == RESP) && rsp_ready;
    assign w_addr_err = dm_addr_err(DM_WORD_WIDTH'(r_addr), DEPTH_WORDS);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)     w_state_nxt = WAIT;
            WAIT:    if (r_cnt == '0)  w_state_nxt = RESP;
            RESP:    if (rsp_ready)    w_state_nxt = IDLE;
            default:                   w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        rsp_valid       = (r_state == RESP);
        // Registered ready follows the state we are about to enter, so it
        // drops on the acceptance edge and rises on the retiring edge.
        w_req_ready_nxt = (w_state_nxt == IDLE);
        w_mem_we        = w_commit &  r_write & ~w_addr_err;
        w_mem_re        = w_commit & ~r_write & ~w_addr_err;
    end

    // ------------------------------------------------------------------
    // Counter, request latch and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_load  <= 1'b0;
        end else begin
            r_req_ready <= w_req_ready_nxt;

            if (w_accept) begin
                r_cnt   <= CW'(WAIT_CYCLES);
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end else if ((r_state == WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_commit) begin
                r_rsp_err  <= w_addr_err;
                r_rsp_load <= ~r_write & ~w_addr_err;
            end else if (w_retire) begin
                r_rsp_err  <= 1'b0;
                r_rsp_load <= 1'b0;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_err   = r_rsp_err;
    // The store's read register has no reset; gate it so rdata is zero out of
    // reset, for stores and for errors.
    assign rsp_rdata = r_rsp_load ? w_mem_rdata : '0;

    // ------------------------------------------------------------------
    // Word array
    // ------------------------------------------------------------------
    dm_store #(
        .WORD_WIDTH  (WORD_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_store (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  (r_addr[AW+1:2]),
        .i_wdata (r_wdata),
        .i_wmask (w_wmask),
        .o_rdata (w_mem_rdata)
    );

endmodule

// File: tb/tb_dm_resp_mem.sv
// Testbench for dm_resp_mem: two instances, WAIT_CYCLES=2 (index 0) and
// WAIT_CYCLES=0 (index 1). Table of request vectors plus hand-written
// sequences for backpressure and reset corner cases.

module tb_dm_resp_mem;

    localparam logic [31:0] EXP_BE =
`ifdef DM_RESP_BYTE_EN
        32'h11BB33DD;
`else
        32'hAABBCCDD;
`endif
    localparam logic [31:0] EXP_BE0 =
`ifdef DM_RESP_BYTE_EN
        32'hDEADBEEF;
`else
        32'h5A5A5A5A;
`endif

    typedef struct {
        int          d;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int n_vec = 0;
    int n_err = 0;

    dm_resp_mem #(.WORD_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dm_resp_mem #(.WORD_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Waits (at most 50 edges) for rsp_valid; n = edges waited.
    task automatic wait_valid(input int d, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!rsp_valid[d] && n < 50);
    endtask

    // Issue one request, return response and latency; rsp_ready[d] assumed 1.
    task automatic do_req(input int d, input vec_t v, input string nm,
                          output logic [31:0] rd, output logic er, output int lat);
        int g;
        g = 0;
        @(negedge clk);
        while (!req_ready[d] && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk({nm, " ready before request"}, {31'b0, req_ready[d]}, 32'd1);
        req_valid[d] = 1'b1;
        req_write[d] = v.wr;
        req_addr[d]  = v.addr;
        req_wdata[d] = v.wdata;
        req_be[d]    = v.be;
        @(posedge clk);
        #1;
        // Requester is free to change everything after acceptance.
        req_valid[d] = 1'b0;
        req_write[d] = ~v.wr;
        req_addr[d]  = v.addr ^ 32'h4;
        req_wdata[d] = ~v.wdata;
        req_be[d]    = ~v.be;
        chk({nm, " ready after accept"}, {31'b0, req_ready[d]}, 32'd0);
        wait_valid(d, lat);
        rd = rsp_rdata[d];
        er = rsp_err[d];
        @(posedge clk);
        #1;
        chk({nm, " ready after retire"}, {31'b0, req_ready[d]}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [$];
        vec_t        v;
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;

        vecs.push_back('{0, 1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{0, 1'b0, 32'h10,   32'h0,        4'hF, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{0, 1'b1, 32'h20,   32'h11223344, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{0, 1'b1, 32'h20,   32'hAABBCCDD, 4'h5, 32'h0,        1'b0});
        vecs.push_back('{0, 1'b0, 32'h20,   32'h0,        4'hF, EXP_BE,       1'b0});
        vecs.push_back('{0, 1'b0, 32'h13,   32'h0,        4'hF, 32'h0,        1'b1});
        vecs.push_back('{0, 1'b1, 32'h0,    32'h01020304, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{0, 1'b1, 32'h1000, 32'h12345678, 4'hF, 32'h0,        1'b1});
        vecs.push_back('{0, 1'b0, 32'h0,    32'h0,        4'hF, 32'h01020304, 1'b0});
        vecs.push_back('{0, 1'b1, 32'hFFC,  32'hCAFEF00D, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{0, 1'b0, 32'hFFC,  32'h0,        4'hF, 32'hCAFEF00D, 1'b0});
        vecs.push_back('{0, 1'b0, 32'h1000, 32'h0,        4'hF, 32'h0,        1'b1});
        vecs.push_back('{0, 1'b0, 32'h2,    32'h0,        4'hF, 32'h0,        1'b1});
        vecs.push_back('{0, 1'b1, 32'h30,   32'h00000077, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{0, 1'b1, 32'h10,   32'h5A5A5A5A, 4'h0, 32'h0,        1'b0});
        vecs.push_back('{0, 1'b0, 32'h10,   32'h0,        4'hF, EXP_BE0,      1'b0});
        vecs.push_back('{1, 1'b1, 32'h40,   32'h0BADF00D, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1, 1'b0, 32'h40,   32'h0,        4'hF, 32'h0BADF00D, 1'b0});
        vecs.push_back('{1, 1'b0, 32'h40,   32'h0,        4'hF, 32'h0BADF00D, 1'b0});
        vecs.push_back('{1, 1'b0, 32'h41,   32'h0,        4'hF, 32'h0,        1'b1});

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_write[d] = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            req_be[d]    = '0;
            rsp_ready[d] = 1'b1;
        end

        // Reset state
        #12;
        chk("reset req_ready", {31'b0, req_ready[0]}, 32'd0);
        chk("reset rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
        chk("reset rsp_rdata", rsp_rdata[0], 32'd0);
        chk("reset rsp_err",   {31'b0, rsp_err[0]},   32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready before first edge", {31'b0, req_ready[0]}, 32'd0);
        @(posedge clk);
        #1;
        chk("ready after first edge", {31'b0, req_ready[0]}, 32'd1);

        // Table-driven requests
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            do_req(v.d, v, $sformatf("v%0d", i), rd, er, lat);
            chk($sformatf("v%0d rdata", i), rd, v.exp_rd);
            chk($sformatf("v%0d err", i), {31'b0, er}, {31'b0, v.exp_err});
            chk($sformatf("v%0d latency", i), lat, (v.d == 0) ? 32'd3 : 32'd1);
        end

        // Backpressure: hold rsp_ready low for 5 cycles after rsp_valid
        @(negedge clk);
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h10;
        rsp_ready[0] = 1'b0;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        wait_valid(0, n);
        chk("bp latency", n, 32'd3);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d rsp_valid", c), {31'b0, rsp_valid[0]}, 32'd1);
            chk($sformatf("bp%0d rsp_rdata", c), rsp_rdata[0], EXP_BE0);
            chk($sformatf("bp%0d req_ready", c), {31'b0, req_ready[0]}, 32'd0);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp retire req_ready", {31'b0, req_ready[0]}, 32'd1);
        chk("bp retire rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h0;
        @(posedge clk);
        #1;
        chk("bp next accepted", {31'b0, req_ready[0]}, 32'd0);
        req_valid[0] = 1'b0;
        wait_valid(0, n);
        chk("bp next rdata", rsp_rdata[0], 32'h01020304);
        @(posedge clk);
        #1;

        // Reset while a response is held in RESP
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h0;
        rsp_ready[0] = 1'b0;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        wait_valid(0, n);
        chk("resp-rst held rdata", rsp_rdata[0], 32'h01020304);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("resp-rst rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
        chk("resp-rst rsp_rdata", rsp_rdata[0], 32'd0);
        chk("resp-rst req_ready", {31'b0, req_ready[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("resp-rst ready rises", {31'b0, req_ready[0]}, 32'd1);

        // Reset one cycle after accepting a store of 0x55 to 0x30
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h30;
        req_wdata[0] = 32'h55; req_be[0] = 4'hF;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("wait-rst req_ready", {31'b0, req_ready[0]}, 32'd0);
        chk("wait-rst rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
        chk("wait-rst rsp_err",   {31'b0, rsp_err[0]},   32'd0);
        @(negedge clk);
        rst = 1'b0;
        v = '{0, 1'b0, 32'h30, 32'h0, 4'hF, 32'h77, 1'b0};
        do_req(0, v, "wait-rst load", rd, er, lat);
        chk("wait-rst load rdata", rd, 32'h00000077);
        chk("wait-rst load err", {31'b0, er}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
